// File: rtl/bist_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bist_sequencer
//  Description : Self-sequencing BIST controller. Runs the ring, Johnson and
//                LFSR pattern generators in turn for PATTERN_COUNT slow ticks
//                each, compacts every sampled pattern into a 16-bit MISR and
//                compares the final signature against a golden value.
//  Revision    : 1.0 - initial release
// ============================================================================
module bist_sequencer #(
    parameter int          PATTERN_COUNT = 16,
    parameter logic [15:0] SEED          = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        tick,
    input  logic [15:0] pattern,
    input  logic [15:0] golden,
    output logic [1:0]  mode,
    output logic        ring_counter_enable,
    output logic        johnson_counter_enable,
    output logic        lfsr_enable,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    // Last counter value of a phase; the phase ends on the tick that sees it.
    localparam logic [15:0] C_LAST_COUNT = 16'(PATTERN_COUNT - 1);

    localparam logic [1:0] C_MODE_IDLE    = 2'b00;
    localparam logic [1:0] C_MODE_RING    = 2'b01;
    localparam logic [1:0] C_MODE_JOHNSON = 2'b10;
    localparam logic [1:0] C_MODE_LFSR    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_RUN_RING    = 3'd1,
        S_RUN_JOHNSON = 3'd2,
        S_RUN_LFSR    = 3'd3,
        S_CHECK       = 3'd4,
        S_DONE        = 3'd5
    } state_e;

    state_e      state_q;
    logic [15:0] count_q;
    logic [15:0] misr_q;
    logic        result_q;

    logic [1:0]  mode_q;
    logic        ring_en_q;
    logic        johnson_en_q;
    logic        lfsr_en_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;

    logic        misr_fb;
    logic [15:0] misr_d;
    logic [15:0] count_d;
    logic        phase_last;

    // MISR next value, tick counter increment and end-of-phase detection.
    always_comb begin
        misr_fb    = misr_q[15] ^ misr_q[14] ^ misr_q[12] ^ misr_q[3];
        misr_d     = {misr_q[14:0], misr_fb} ^ pattern;
        count_d    = count_q + 16'd1;
        phase_last = (count_q == C_LAST_COUNT);
    end

    // Sequencer FSM; every output is registered from the state it leaves,
    // so outputs trail the state register by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            count_q      <= 16'd0;
            misr_q       <= SEED;
            result_q     <= 1'b0;
            mode_q       <= C_MODE_IDLE;
            ring_en_q    <= 1'b0;
            johnson_en_q <= 1'b0;
            lfsr_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            // Output decode of the current state (overridden on a start capture).
            ring_en_q    <= (state_q == S_RUN_RING);
            johnson_en_q <= (state_q == S_RUN_JOHNSON);
            lfsr_en_q    <= (state_q == S_RUN_LFSR);
            busy_q       <= (state_q == S_RUN_RING) || (state_q == S_RUN_JOHNSON) ||
                            (state_q == S_RUN_LFSR) || (state_q == S_CHECK);
            done_q       <= (state_q == S_DONE);
            pass_q       <= (state_q == S_DONE) && result_q;
            case (state_q)
                S_RUN_RING:    mode_q <= C_MODE_RING;
                S_RUN_JOHNSON: mode_q <= C_MODE_JOHNSON;
                S_RUN_LFSR:    mode_q <= C_MODE_LFSR;
                default:       mode_q <= C_MODE_IDLE;
            endcase

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q  <= S_RUN_RING;
                        count_q  <= 16'd0;
                        misr_q   <= SEED;
                        result_q <= 1'b0;
                        // A restart drops the previous verdict immediately.
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                    end
                end
                S_RUN_RING, S_RUN_JOHNSON, S_RUN_LFSR: begin
                    if (tick) begin
                        misr_q <= misr_d;
                        if (phase_last) begin
                            count_q <= 16'd0;
                            case (state_q)
                                S_RUN_RING:    state_q <= S_RUN_JOHNSON;
                                S_RUN_JOHNSON: state_q <= S_RUN_LFSR;
                                default:       state_q <= S_CHECK;
                            endcase
                        end else begin
                            count_q <= count_d;
                        end
                    end
                end
                S_CHECK: begin
                    result_q <= (misr_q == golden);
                    state_q  <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mode                   = mode_q;
    assign ring_counter_enable    = ring_en_q;
    assign johnson_counter_enable = johnson_en_q;
    assign lfsr_enable            = lfsr_en_q;
    assign busy                   = busy_q;
    assign done                   = done_q;
    assign pass                   = pass_q;
    assign signature              = misr_q;

endmodule
`default_nettype wire

// File: tb/tb_bist_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bist_sequencer
//  Description : Self-checking bench for bist_sequencer. Three instances with
//                different PATTERN_COUNT / SEED share the data inputs; each
//                test starts only the instance it exercises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bist_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [15:0] pattern;
    logic [15:0] golden;
    logic        start_w [3];

    logic [1:0]  mode_w  [3];
    logic        ring_w  [3];
    logic        john_w  [3];
    logic        lfsr_w  [3];
    logic        busy_w  [3];
    logic        done_w  [3];
    logic        pass_w  [3];
    logic [15:0] sig_w   [3];

    always #5 clk = ~clk;

    bist_sequencer #(.PATTERN_COUNT(4), .SEED(16'h0000)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_w[0]), .tick(tick), .pattern(pattern), .golden(golden),
        .mode(mode_w[0]), .ring_counter_enable(ring_w[0]), .johnson_counter_enable(john_w[0]),
        .lfsr_enable(lfsr_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .signature(sig_w[0]));

    bist_sequencer #(.PATTERN_COUNT(1), .SEED(16'h0000)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_w[1]), .tick(tick), .pattern(pattern), .golden(golden),
        .mode(mode_w[1]), .ring_counter_enable(ring_w[1]), .johnson_counter_enable(john_w[1]),
        .lfsr_enable(lfsr_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .signature(sig_w[1]));

    bist_sequencer #(.PATTERN_COUNT(2), .SEED(16'hA5A5)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_w[2]), .tick(tick), .pattern(pattern), .golden(golden),
        .mode(mode_w[2]), .ring_counter_enable(ring_w[2]), .johnson_counter_enable(john_w[2]),
        .lfsr_enable(lfsr_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .signature(sig_w[2]));

    // en is {lfsr, johnson, ring}
    typedef struct packed {
        logic [1:0]  mode;
        logic [2:0]  en;
        logic        busy;
        logic        done;
        logic        pass;
        logic [15:0] sig;
    } out_t;

    typedef struct {
        int          dut;
        logic        rs;
        logic        st;
        logic        tk;
        logic [15:0] pat;
        logic [15:0] gold;
        out_t        exp;
        string       name;
    } vec_t;

    int total = 0;
    int bad   = 0;

    out_t  exp_q  [$];
    int    dut_q  [$];
    string name_q [$];

    vec_t  tab_a  [$];
    vec_t  tab_b  [$];

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] p);
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ p;
    endfunction

    // Expected output record; enables follow from the mode code.
    function automatic out_t mk_out(input int m, input logic b, input logic d,
                                    input logic p, input logic [15:0] s);
        out_t o;
        o.mode = 2'(m);
        case (m)
            1:       o.en = 3'b001;
            2:       o.en = 3'b010;
            3:       o.en = 3'b100;
            default: o.en = 3'b000;
        endcase
        o.busy = b;
        o.done = d;
        o.pass = p;
        o.sig  = s;
        return o;
    endfunction

    function automatic vec_t mk_vec(input int d, input logic rs, input logic st, input logic tk,
                                    input logic [15:0] pat, input logic [15:0] gold,
                                    input out_t e, input string n);
        vec_t v;
        v.dut = d; v.rs = rs; v.st = st; v.tk = tk;
        v.pat = pat; v.gold = gold; v.exp = e; v.name = n;
        return v;
    endfunction

    function automatic out_t get_out(input int d);
        out_t o;
        o.mode = mode_w[d];
        o.en   = {lfsr_w[d], john_w[d], ring_w[d]};
        o.busy = busy_w[d];
        o.done = done_w[d];
        o.pass = pass_w[d];
        o.sig  = sig_w[d];
        return o;
    endfunction

    task automatic compare(input int d, input out_t e, input string n);
        out_t a;
        a = get_out(d);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s dut%0d: got mode=%b en=%b busy=%b done=%b pass=%b sig=%h, want mode=%b en=%b busy=%b done=%b pass=%b sig=%h",
                     n, d, a.mode, a.en, a.busy, a.done, a.pass, a.sig,
                     e.mode, e.en, e.busy, e.done, e.pass, e.sig);
        end
    endtask

    // Drive one vector, queue its expectation, and check after the edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst     = v.rs;
        for (int i = 0; i < 3; i++) start_w[i] = 1'b0;
        start_w[v.dut] = v.st;
        tick    = v.tk;
        pattern = v.pat;
        golden  = v.gold;
        exp_q.push_back(v.exp);
        dut_q.push_back(v.dut);
        name_q.push_back(v.name);
        @(posedge clk);
        #1;
        compare(dut_q.pop_front(), exp_q.pop_front(), name_q.pop_front());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sig_m;
        int          m;
        logic        st, tk, b, d, p;
        logic [15:0] gval;

        // Table A: PATTERN_COUNT=4, tick every cycle, pattern=0, golden=0.
        tab_a.push_back(mk_vec(0, 0, 1, 1, 16'h0, 16'h0, mk_out(0, 0, 0, 0, 16'h0), "A_start"));
        for (int k = 1; k <= 15; k++) begin
            m = (k <= 4) ? 1 : (k <= 8) ? 2 : (k <= 12) ? 3 : 0;
            tab_a.push_back(mk_vec(0, 0, 0, 1, 16'h0, 16'h0,
                                   mk_out(m, k <= 13, k >= 14, k >= 14, 16'h0), "A_run"));
        end

        // Table B: PATTERN_COUNT=1, pattern=1; golden 7 passes, then a restart with golden 8 fails.
        for (int r = 0; r < 2; r++) begin
            gval = (r == 0) ? 16'h0007 : 16'h0008;
            tab_b.push_back(mk_vec(1, 0, 1, 1, 16'h1, gval, mk_out(0, 0, 0, 0, 16'h0), "B_start"));
            tab_b.push_back(mk_vec(1, 0, 0, 1, 16'h1, gval, mk_out(1, 1, 0, 0, 16'h0001), "B_ring"));
            tab_b.push_back(mk_vec(1, 0, 0, 1, 16'h1, gval, mk_out(2, 1, 0, 0, 16'h0003), "B_john"));
            tab_b.push_back(mk_vec(1, 0, 0, 1, 16'h1, gval, mk_out(3, 1, 0, 0, 16'h0007), "B_lfsr"));
            tab_b.push_back(mk_vec(1, 0, 0, 1, 16'h1, gval, mk_out(0, 1, 0, 0, 16'h0007), "B_check"));
            tab_b.push_back(mk_vec(1, 0, 0, 1, 16'h1, gval, mk_out(0, 0, 1, r == 0, 16'h0007), "B_done"));
        end

        rst = 1'b1; tick = 1'b0; pattern = '0; golden = '0;
        for (int i = 0; i < 3; i++) start_w[i] = 1'b0;

        // Reset: two cycles of rst, start alongside rst is ignored.
        apply(mk_vec(0, 1, 0, 0, 16'h0, 16'h0, mk_out(0, 0, 0, 0, 16'h0), "R_rst1"));
        apply(mk_vec(0, 1, 1, 1, 16'h0, 16'h0, mk_out(0, 0, 0, 0, 16'h0), "R_rst_start"));
        apply(mk_vec(0, 0, 0, 1, 16'h0, 16'h0, mk_out(0, 0, 0, 0, 16'h0), "R_idle"));
        compare(1, mk_out(0, 0, 0, 0, 16'h0000), "R_dut1");
        compare(2, mk_out(0, 0, 0, 0, 16'hA5A5), "R_dut2_seed");

        foreach (tab_a[i]) apply(tab_a[i]);
        foreach (tab_b[i]) apply(tab_b[i]);

        // Tick every 4th cycle, PATTERN_COUNT=2, random patterns, start pulse mid-run.
        sig_m = 16'hA5A5;
        for (int k = 0; k <= 26; k++) begin
            logic [15:0] pv;
            pv = 16'($urandom);
            st = (k == 0) || (k == 10);
            tk = (k % 4) == 3;
            gval = sig_m;
            if (tk && k >= 3 && k <= 23) sig_m = misr_step(sig_m, pv);
            m = (k >= 1 && k <= 7) ? 1 : (k >= 8 && k <= 15) ? 2 : (k >= 16 && k <= 23) ? 3 : 0;
            b = (k >= 1 && k <= 24);
            d = (k >= 25);
            p = (k >= 25);
            apply(mk_vec(2, 0, st, tk, pv, gval, mk_out(m, b, d, p, sig_m), "C_slow"));
        end

        // rst during RUN_LFSR, coinciding with the phase-final tick.
        sig_m = 16'h0000;
        apply(mk_vec(0, 0, 1, 1, 16'h1, 16'h0, mk_out(0, 0, 0, 0, 16'h0), "D_start"));
        for (int k = 1; k <= 11; k++) begin
            sig_m = misr_step(sig_m, 16'h1);
            m = (k <= 4) ? 1 : (k <= 8) ? 2 : 3;
            apply(mk_vec(0, 0, 0, 1, 16'h1, 16'h0, mk_out(m, 1, 0, 0, sig_m), "D_run"));
        end
        apply(mk_vec(0, 1, 0, 1, 16'h1, 16'h0, mk_out(0, 0, 0, 0, 16'h0), "D_rst"));
        compare(1, mk_out(0, 0, 0, 0, 16'h0000), "D_rst_dut1");
        compare(2, mk_out(0, 0, 0, 0, 16'hA5A5), "D_rst_dut2");
        apply(mk_vec(0, 0, 0, 1, 16'h1, 16'h0, mk_out(0, 0, 0, 0, 16'h0), "D_idle_tick"));

        // Full sequence again after the reset.
        foreach (tab_a[i]) apply(tab_a[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bist_sequencer.md
# bist_sequencer

Autonomous self-test sequencer for the BIST pattern generators (ring counter, Johnson counter, LFSR). On a start request it runs each generator in turn for a programmed number of slow-clock ticks and compresses every sampled 16-bit pattern into a MISR signature. It then compares the signature against a golden value and reports pass/fail. It sits between the board-level control inputs and the BIST datapath, replacing manual mode selection with a self-sequenced run.

## Interface
Parameters:
- PATTERN_COUNT, 16, ticks spent in each generator phase (legal range 1..65535)
- SEED, 16'h0000, MISR value loaded at the start of a run

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  run request; sampled only in IDLE or DONE
- tick  input  1  one-cycle slow-clock enable; all pattern sampling and counting is qualified by it
- pattern  input  16  current generator output from the datapath
- golden  input  16  expected signature; sampled in CHECK
- mode  output  2  datapath mode: 00 idle, 01 ring, 10 Johnson, 11 LFSR
- ring_counter_enable  output  1  high throughout RUN_RING
- johnson_counter_enable  output  1  high throughout RUN_JOHNSON
- lfsr_enable  output  1  high throughout RUN_LFSR
- busy  output  1  high in any RUN state or CHECK
- done  output  1  high in DONE
- pass  output  1  result; valid while done=1, otherwise 0
- signature  output  16  current MISR contents

## Operation
- States: IDLE, RUN_RING, RUN_JOHNSON, RUN_LFSR, CHECK, DONE.
- IDLE/DONE + start=1 -> RUN_RING. On that edge: MISR<=SEED, phase counter<=0, done<=0, pass<=0.
- RUN_x + tick=1:
  - MISR updates: sig <= {sig[14:0], fb} ^ pattern, where fb = sig[15]^sig[14]^sig[12]^sig[3].
  - Counter increments.
  - When the counter equals PATTERN_COUNT-1 on a tick: counter clears and the state advances (RING->JOHNSON->LFSR->CHECK).
- RUN_x + tick=0: counter and MISR hold.
- CHECK: single cycle. pass <= (signature == golden). Next state is DONE.
- DONE: done=1; pass and signature hold until the next start or rst.
- start is ignored in RUN states and CHECK.
- Enables are one-hot and registered from the state. mode is 00 in IDLE, CHECK and DONE.
- Counter is 16 bits wide; no wrap occurs within a legal PATTERN_COUNT.

## Timing
- Reset value of every output is 0: mode=00, all enables 0, busy=0, done=0, pass=0, signature=SEED.
- rst has priority over all other inputs. Asserting rst mid-run returns the block to IDLE on the same edge and clears all outputs as above.
- start to busy/ring_counter_enable: 1 cycle.
- pattern is sampled on the tick edge, before the generator advances on that edge.
- The last tick of one phase and the enable of the next phase are separated by exactly 1 cycle; no dead tick is inserted.
- With tick held high, done rises 3·PATTERN_COUNT+2 cycles after the edge on which start is captured.
- If tick and the phase-final count coincide with rst, rst wins.
- A tick arriving during CHECK or DONE is ignored.

## Test plan
- Reset: hold rst 2 cycles -> all outputs 0 and signature=16'h0000. Drive start=1 together with rst -> block stays in IDLE.
- PATTERN_COUNT=4, tick=1 every cycle, pattern=0, golden=0, start pulse at edge 0:
  - ring_counter_enable high for cycles 1–4, johnson_counter_enable for 5–8, lfsr_enable for 9–12.
  - CHECK at cycle 13.
  - done=1 and pass=1 from cycle 14, with signature=16'h0000.
- PATTERN_COUNT=1, pattern held at 16'h0001: signature steps 0x0001, 0x0003, 0x0007.
  - golden=16'h0007 -> pass=1.
  - Repeat with golden=16'h0008 -> pass=0, done=1.
- Tick every 4th cycle, PATTERN_COUNT=2: each phase lasts 8 cycles and signature changes only on tick edges. Pulse start mid-run -> no effect.
- rst asserted during RUN_LFSR -> next cycle all outputs 0 and mode=00. A following start runs the full sequence normally.
- Restart from DONE: start=1 -> done and pass drop, signature reloads SEED, and ring phase begins 1 cycle later.
